// File: rtl/error_checker_pkg.sv
// Shared defaults and state encoding for the error checker sequencer.
package error_checker_pkg;

  localparam int DEFAULT_NUM_SAMPLES = 150;
  localparam int DEFAULT_DATA_W      = 20;
  localparam int DEFAULT_SEL_W       = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CALC  = 2'd2,
    DRAIN = 2'd3
  } seq_state_t;

endpackage

// File: rtl/error_checker_sequencer_if.sv
// Sample-load and error-read bus between the sequencer (master) and the
// datapath/consumer side (slave).
interface error_checker_sequencer_if
  import error_checker_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int SEL_W  = DEFAULT_SEL_W
);

  logic              in_valid;
  logic              in_ready;
  logic              load;
  logic [SEL_W-1:0]  register_load_select;
  logic [SEL_W-1:0]  output_select;
  logic [DATA_W-1:0] error_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] error_out;
  logic [SEL_W-1:0]  out_index;

  modport master (
    input  in_valid,
    input  error_in,
    input  out_ready,
    output in_ready,
    output load,
    output register_load_select,
    output output_select,
    output out_valid,
    output error_out,
    output out_index
  );

  modport slave (
    output in_valid,
    output error_in,
    output out_ready,
    input  in_ready,
    input  load,
    input  register_load_select,
    input  output_select,
    input  out_valid,
    input  error_out,
    input  out_index
  );

endinterface

// File: rtl/error_checker_sequencer_sample_counter.sv
// Index counter with synchronous clear; returns to zero after the terminal
// count so it never exceeds COUNT_MAX-1.
module sample_counter #(
  parameter int COUNT_MAX = 150,
  parameter int W         = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         last
);

  localparam logic [W-1:0] LAST_VAL = W'(COUNT_MAX - 1);

  assign last = (count == LAST_VAL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= last ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/error_checker_sequencer.sv
// Loads NUM_SAMPLES x/y register pairs, then reads back one error per sample.
// Optional threshold counter is enabled by defining ERROR_CHECKER_THRESH_EN.
module error_checker_sequencer
  import error_checker_pkg::*;
#(
  parameter int NUM_SAMPLES = DEFAULT_NUM_SAMPLES,
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int SEL_W       = DEFAULT_SEL_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  error_checker_sequencer_if.master  bus,
  output logic                       busy,
  output logic                       done
`ifdef ERROR_CHECKER_THRESH_EN
  ,
  input  logic [DATA_W-1:0]          threshold,
  output logic [SEL_W:0]             over_count
`endif
);

  if (NUM_SAMPLES < 1 || NUM_SAMPLES > (2 ** SEL_W)) begin : g_bad_params
    $error("error_checker_sequencer: NUM_SAMPLES must be in 1..2**SEL_W");
  end

  seq_state_t        state;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] error_q;
  logic [SEL_W-1:0]  index_q;

  logic [SEL_W-1:0]  ld_count;
  logic [SEL_W-1:0]  rd_count;
  logic              ld_last;
  logic              rd_last;

  logic              start;
  logic              accept;
  logic              capture;

  assign start   = (state == IDLE) && en;
  assign accept  = bus.in_valid && in_ready_q;
  // Output register refills whenever it is empty or being drained this cycle.
  assign capture = (state == CALC) && (!out_valid_q || bus.out_ready);

  sample_counter #(
    .COUNT_MAX (NUM_SAMPLES),
    .W         (SEL_W)
  ) u_load_counter (
    .clk   (clk),
    .reset (reset),
    .clear (start),
    .inc   (accept),
    .count (ld_count),
    .last  (ld_last)
  );

  sample_counter #(
    .COUNT_MAX (NUM_SAMPLES),
    .W         (SEL_W)
  ) u_read_counter (
    .clk   (clk),
    .reset (reset),
    .clear (start),
    .inc   (capture),
    .count (rd_count),
    .last  (rd_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      error_q     <= '0;
      index_q     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            state      <= LOAD;
            in_ready_q <= 1'b1;
            busy       <= 1'b1;
          end
        end
        LOAD: begin
          if (accept && ld_last) begin
            state      <= CALC;
            in_ready_q <= 1'b0;
          end
        end
        CALC: begin
          if (capture) begin
            error_q     <= bus.error_in;
            index_q     <= rd_count;
            out_valid_q <= 1'b1;
            if (rd_last) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready             = in_ready_q;
  assign bus.load                 = accept;
  assign bus.register_load_select = (state == LOAD) ? ld_count : '0;
  assign bus.output_select        = (state == CALC) ? rd_count : '0;
  assign bus.out_valid            = out_valid_q;
  assign bus.error_out            = error_q;
  assign bus.out_index            = index_q;

`ifdef ERROR_CHECKER_THRESH_EN
  // Magnitude of a two's complement error; the most negative value maps to 2**(DATA_W-1).
  logic [DATA_W-1:0] error_mag;

  assign error_mag = bus.error_in[DATA_W-1] ? (~bus.error_in + 1'b1) : bus.error_in;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      over_count <= '0;
    end else if (start) begin
      over_count <= '0;
    end else if (capture && (error_mag > threshold)) begin
      over_count <= over_count + 1'b1;
    end
  end
`endif

endmodule

// File: doc/error_checker_sequencer.md
ERROR_CHECKER_SEQUENCER -- requirements
Module: error_checker_sequencer

Interface
REQ-001 SHALL have parameter NUM_SAMPLES, default 150, number of x/y sample register pairs sequenced.
REQ-002 SHALL have parameter DATA_W, default 20, error/data width.
REQ-003 SHALL have parameter SEL_W, default 8, select width; SHALL satisfy NUM_SAMPLES <= 2**SEL_W.
REQ-004 Ports SHALL be:
- clk  in  1  single clock, rising-edge.
- reset  in  1  asynchronous, active-low.
- en  in  1  start request, sampled in IDLE only.
- in_valid  in  1  sample pair present on datapath x_Bus/y_Bus.
- in_ready  out  1  sequencer accepts a sample this cycle.
- load  out  1  datapath register write strobe.
- register_load_select  out  SEL_W  datapath register index to write.
- output_select  out  SEL_W  datapath mux select for error read.
- error_in  in  DATA_W  combinational datapath error for output_select.
- out_valid  out  1  error_out/out_index valid.
- out_ready  in  1  consumer accepts error_out.
- error_out  out  DATA_W  registered error value.
- out_index  out  SEL_W  sample index of error_out.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse after final error handshake.

Function
REQ-005 States SHALL be IDLE, LOAD, CALC, DRAIN; encoding defined in package.
REQ-006 IDLE: in_ready=0, load=0; en=1 -> LOAD with load counter=0; en ignored in all other states.
REQ-007 LOAD: in_ready=1; load = in_valid & in_ready (combinational); register_load_select = load counter.
REQ-008 LOAD: each accepted sample SHALL increment load counter by 1; acceptance at index NUM_SAMPLES-1 -> CALC with read counter=0; load counter never exceeds NUM_SAMPLES-1.
REQ-009 LOAD with in_valid=0 SHALL hold state and counter indefinitely.
REQ-010 CALC: output_select = read counter; output register SHALL capture error_in and out_index=read counter, set out_valid=1 when out_valid=0 or out_ready=1 (one-cycle latency, full throughput).
REQ-011 CALC: each capture increments read counter; capture at index NUM_SAMPLES-1 -> DRAIN.
REQ-012 out_valid=1 with out_ready=0 SHALL hold error_out, out_index, read counter stable.
REQ-013 DRAIN: no capture; out_valid & out_ready -> out_valid=0, done=1 for one cycle, -> IDLE.
REQ-014 output_select SHALL equal 0 outside CALC; register_load_select SHALL equal 0 outside LOAD.
REQ-015 Exactly NUM_SAMPLES load strobes and NUM_SAMPLES output handshakes SHALL occur per run, indices 0..NUM_SAMPLES-1 in order, no wrap.
REQ-016 error_out SHALL be error_in unmodified (datapath owns arithmetic, modulo 2**DATA_W).

Reset
REQ-017 reset=0 SHALL asynchronously force IDLE, counters=0, out_valid=0, error_out=0, out_index=0, done=0, load=0, in_ready=0; mid-run reset abandons run with no done pulse.

Configuration
REQ-018 Macro ERROR_CHECKER_THRESH_EN defined: adds input threshold [DATA_W] and output over_count [SEL_W+1]; over_count cleared on LOAD entry, incremented per capture where |error_in| (two's complement) > threshold, held after done until next run; reset value 0.
REQ-019 Macro undefined: ports threshold/over_count and logic SHALL be absent; all other behaviour identical.

Structure
REQ-020 Package error_checker_pkg SHALL hold NUM_SAMPLES, DATA_W, SEL_W defaults and state typedef.
REQ-021 One sub-module sample_counter (clear, increment, terminal-count flag at NUM_SAMPLES-1) SHALL be instanced twice (load, read).

Verification
REQ-022 reset low mid-LOAD at index 40 -> IDLE, busy=0, no done; fresh en restarts at index 0.
REQ-023 NUM_SAMPLES=4, en pulse, in_valid=1 constant -> load high 4 cycles, selects 0,1,2,3, then CALC.
REQ-024 in_valid toggling 1/0 in LOAD -> only accepted cycles advance register_load_select; 4 strobes total.
REQ-025 error_in=index*3, out_ready=1 -> error_out 0,3,6,9 on consecutive cycles, done one cycle after last handshake.
REQ-026 out_ready=0 for 5 cycles at index 2 -> error_out=6, out_index=2 held stable; no index skipped or repeated.
REQ-027 THRESH_EN, threshold=5, errors {-7,2,6,5} -> over_count=2 after done.
